stream_mux_arb: RTL

Parametrised N-input, one-output streaming multiplexer with registered output and per-channel valid/ready handshakes. It replaces the fixed 4:1 combinational select with arbitration. Each source asserts valid, the arbiter grants one source per accepted beat, and the beat is captured in a single output register, along with the index of the winning channel. It sits between multiple producer datapaths and one shared downstream consumer.

---
 rtl/stream_mux_pkg.sv | 23 ++
 rtl/stream_mux_arb_rr_arbiter.sv | 79 +++++++
 rtl/stream_mux_arb.sv | 79 +++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
//==============================================================================
// stream_mux_pkg : shared types and helpers for the stream_mux_arb slice
// Revision: 1.0
//==============================================================================
`default_nettype none

package stream_mux_pkg;

   localparam int STREAM_MUX_MAX_CH = 32;

   typedef logic [STREAM_MUX_MAX_CH-1:0] gnt_vec_t;

   // Index width that never collapses to zero, even for a single channel.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
//==============================================================================
// rr_arbiter : one-hot grant over N_CH requests, round-robin when
//              STREAM_MUX_ARB_RR_EN is defined, fixed lowest-index otherwise
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = clog2_min1(N_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_CH-1:0]   i_req,
   input  logic              i_adv,
   output logic [N_CH-1:0]   o_gnt,
   output logic [SEL_W-1:0]  o_gnt_idx
);

   logic [N_CH-1:0]  w_gnt;
   logic [SEL_W-1:0] w_idx;
   logic             w_found;

`ifdef STREAM_MUX_ARB_RR_EN
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W:0]   w_ch;

   // Walk channels starting at the pointer, wrapping modulo N_CH.
   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      w_ch    = '0;
      for (int off = 0; off < N_CH; off++) begin
         w_ch = {1'b0, r_ptr} + (SEL_W+1)'(off);
         if (w_ch >= (SEL_W+1)'(N_CH)) w_ch = w_ch - (SEL_W+1)'(N_CH);
         if (!w_found && i_req[w_ch[SEL_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_ch[SEL_W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (i_adv)
         r_ptr <= (w_idx == SEL_W'(N_CH-1)) ? '0 : w_idx + 1'b1;
   end
`else
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, i_clk, i_adv};

   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = N_CH-1; k >= 0; k--) begin
         if (i_req[k]) begin
            w_found = 1'b1;
            w_idx   = SEL_W'(k);
         end
      end
   end
`endif

   always_comb begin
      w_gnt = '0;
      for (int k = 0; k < N_CH; k++)
         w_gnt[k] = w_found && (w_idx == SEL_W'(k));
   end

   // Grant is forced off while reset is held so no source sees o_ready.
   assign o_gnt     = i_rst_n ? w_gnt : '0;
   assign o_gnt_idx = w_idx;

endmodule

`default_nettype wire

// File: rtl/stream_mux_arb.sv
//==============================================================================
// stream_mux_arb : N-input arbitrated stream mux with registered output
//                  (STREAM_MUX_ARB_RR_EN selects round-robin arbitration)
// Revision: 1.0
//==============================================================================
`default_nettype none

module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = 2,
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [N_CH-1:0]        i_valid,
   input  logic [N_CH*DATA_W-1:0] i_data,
   output logic [N_CH-1:0]        o_ready,
   output logic                   o_valid,
   output logic [DATA_W-1:0]      o_data,
   output logic [SEL_W-1:0]       o_sel,
   input  logic                   i_ready
);

   logic [N_CH-1:0]   w_gnt;
   logic [SEL_W-1:0]  w_gnt_idx;
   logic              w_load;
   logic              w_xfer;
   logic [DATA_W-1:0] w_beat;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [SEL_W-1:0]  r_sel;

   assign w_load  = ~r_valid | i_ready;
   assign w_xfer  = w_load & (|w_gnt);
   assign o_ready = w_load ? w_gnt : '0;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_arb (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     (i_valid),
      .i_adv     (w_xfer),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_beat = '0;
      for (int k = 0; k < N_CH; k++)
         if (w_gnt[k]) w_beat = i_data[k*DATA_W +: DATA_W];
   end

   // Data and index only move on a transfer; an idle load just empties.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_load) begin
         r_valid <= w_xfer;
         if (w_xfer) begin
            r_data <= w_beat;
            r_sel  <= w_gnt_idx;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_sel   = r_sel;

endmodule

`default_nettype wire
